// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue of {pc, inst} pairs.
// Fetches one word per cycle from a combinational instruction memory. Decode
// drains the queue over valid/ready. A redirect flushes the queue and reloads the PC.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_addr,
  output logic [XLEN-1:0]          imem_addr,
  output logic                     imem_en,
  input  logic [XLEN-1:0]          imem_data,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          id_inst,
  output logic [XLEN-1:0]          id_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_INIT  = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] r_fetch_pc;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic [XLEN-1:0] r_q_pc   [DEPTH];
  logic [XLEN-1:0] r_q_inst [DEPTH];

  logic w_pop;
  logic w_push;
  logic w_full;
  logic w_unused_addr_lsb;

  // Word-aligned targets only; the low address bits are intentionally dropped.
  assign w_unused_addr_lsb = ^redirect_addr[1:0];

  assign w_full   = (r_count == FULL_CNT);
  assign id_valid = (r_count != '0);
  assign w_pop    = id_valid & id_ready;
  // Holding push low during reset keeps imem_en at its reset value immediately.
  assign w_push   = ~reset & ~redirect & (~w_full | w_pop);

  assign imem_addr = r_fetch_pc;
  assign imem_en   = w_push;
  assign count     = r_count;

  // Head entry is presented combinationally; zeros when the queue is empty.
  assign id_inst = id_valid ? r_q_inst[r_rd_ptr] : '0;
  assign id_pc   = id_valid ? r_q_pc[r_rd_ptr]   : '0;

  // Fetch PC, pointers and occupancy; redirect overrides any push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= PC_INIT;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_addr[XLEN-1:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
      r_q_inst[r_wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: XLEN=32, DEPTH=4, RESET_PC=0x100.
// Instruction memory returns addr ^ 0xA5A5A5A5.
module tb_fetch_queue_stage;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .count(count)
  );

  assign imem_data = imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_inst"}, id_inst, pc ^ KEY);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_addr = '0; id_ready = 1'b1;
    tick(); tick();
    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_addr", imem_addr, 32'h100);

    // 1: streaming with id_ready=1, one instruction per cycle in order
    reset = 1'b0;
    #1;
    chk("t1_en", 32'(imem_en), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_head("t1_head", 32'h100 + 32'(4*i));
      chk("t1_count", 32'(count), 32'd1);
    end

    // 2: stall decode for 10 cycles; queue fills to DEPTH, fetch stops
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_head("t2_stable", 32'h110);
    end
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_en", 32'(imem_en), 32'd0);
    chk("t2_addr", imem_addr, 32'h120);

    // 3: full queue with steady ready; push and pop every cycle, pointers wrap
    id_ready = 1'b1;
    #1;
    chk("t3_en_full_pop", 32'(imem_en), 32'd1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_head("t3_head", 32'h110 + 32'(4*k));
      chk("t3_count", 32'(count), 32'd4);
    end
    chk("t3_addr", imem_addr, 32'h158);

    // 4: redirect with three entries queued
    reset = 1'b1; #2; reset = 1'b0;
    id_ready = 1'b0;
    tick(); tick(); tick();
    chk("t4_count3", 32'(count), 32'd3);
    chk_head("t4_head_pre", 32'h100);
    redirect = 1'b1; redirect_addr = 32'h2003; id_ready = 1'b1;
    #1;
    chk("t4_en_redir", 32'(imem_en), 32'd0);
    tick();
    redirect = 1'b0;
    chk("t4_count0", 32'(count), 32'd0);
    chk("t4_valid0", 32'(id_valid), 32'd0);
    chk("t4_pc0", id_pc, 32'h0);
    chk("t4_addr", imem_addr, 32'h2000);
    tick();
    chk_head("t4_first", 32'h2000);
    tick();
    chk_head("t4_second", 32'h2004);

    // Back-to-back redirects: last one wins, queue stays empty meanwhile
    redirect = 1'b1; redirect_addr = 32'h3000;
    tick();
    chk("t4b_count_a", 32'(count), 32'd0);
    redirect_addr = 32'h4009;
    tick();
    chk("t4b_count_b", 32'(count), 32'd0);
    chk("t4b_addr", imem_addr, 32'h4008);
    redirect = 1'b0;
    tick();
    chk_head("t4b_first", 32'h4008);

    // 5: reset asserted between edges takes effect at once
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_valid", 32'(id_valid), 32'd0);
    chk("t5_pc", id_pc, 32'h0);
    chk("t5_inst", id_inst, 32'h0);
    chk("t5_en", 32'(imem_en), 32'd0);
    chk("t5_addr", imem_addr, 32'h100);
    tick();
    reset = 1'b0;
    tick();
    chk_head("t5_restart", 32'h100);

    // 6: fetch PC wraps modulo 2^32
    redirect = 1'b1; redirect_addr = 32'hFFFFFFFC;
    tick();
    redirect = 1'b0;
    chk("t6_addr_top", imem_addr, 32'hFFFFFFFC);
    tick();
    chk_head("t6_top", 32'hFFFFFFFC);
    chk("t6_addr_wrap", imem_addr, 32'h0);
    tick();
    chk_head("t6_wrap", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
